calc1_port_scheduler: RTL

- Front-end scheduler for calc1. Accepts the four requester command streams, in calc1 request protocol, and captures the two operands of each request.
- Arbitrates pending requests round-robin onto a single shared, non-pipelined execution unit.
- Routes each result back to the originating port as a one-cycle response.
- Sits between the requester side (the driver) and the shared ALU.

---
 rtl/calc1_port_scheduler_if.sv | 29 ++
 rtl/calc1_port_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_scheduler_if.sv
// rtl/calc1_port_scheduler_if.sv - requester and shared-unit signal bundle for calc1_port_scheduler
interface calc1_port_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
);
    logic [4*CMD_W-1:0]  req_cmd_in;
    logic [4*DATA_W-1:0] req_data_in;
    logic [4*DATA_W-1:0] out_data;
    logic [7:0]          out_resp;
    logic                alu_valid;
    logic [CMD_W-1:0]    alu_cmd;
    logic [DATA_W-1:0]   alu_op1;
    logic [DATA_W-1:0]   alu_op2;
    logic                alu_ready;
    logic                alu_done;
    logic [DATA_W-1:0]   alu_result;
    logic [1:0]          alu_resp;
    logic [3:0]          busy_ports;

    modport master (
        output req_cmd_in, req_data_in, alu_ready, alu_done, alu_result, alu_resp,
        input  out_data, out_resp, alu_valid, alu_cmd, alu_op1, alu_op2, busy_ports
    );

    modport slave (
        input  req_cmd_in, req_data_in, alu_ready, alu_done, alu_result, alu_resp,
        output out_data, out_resp, alu_valid, alu_cmd, alu_op1, alu_op2, busy_ports
    );
endinterface

// File: rtl/calc1_port_scheduler.sv
// rtl/calc1_port_scheduler.sv - four-port round-robin front end for the shared calc1 unit
module calc1_port_scheduler #(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 255
) (
    input logic c_clk,
    input logic reset,
    calc1_port_scheduler_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_OP2, S_PEND, S_ISSUED, S_RESP} port_state_e;

    // Counter holds cycles since issue minus one, so the limit fires one edge early
    // and the timeout response lands exactly TIMEOUT cycles after the issue strobe.
    localparam logic [10:0] TMO_LIM = 11'(TIMEOUT);

    port_state_e        state_q [4];
    port_state_e        state_d [4];
    logic [CMD_W-1:0]   cmd_q   [4];
    logic [CMD_W-1:0]   cmd_d   [4];
    logic [DATA_W-1:0]  op1_q   [4];
    logic [DATA_W-1:0]  op1_d   [4];
    logic [DATA_W-1:0]  op2_q   [4];
    logic [DATA_W-1:0]  op2_d   [4];
    logic [DATA_W-1:0]  rdata_q [4];
    logic [DATA_W-1:0]  rdata_d [4];
    logic [1:0]         rcode_q [4];
    logic [1:0]         rcode_d [4];

    logic               unit_busy_q, unit_busy_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [10:0]        tmo_cnt_q, tmo_cnt_d;
    logic [CMD_W-1:0]   alu_cmd_q, alu_cmd_d;
    logic [DATA_W-1:0]  alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0]  alu_op2_q, alu_op2_d;

    logic               grant_vld;
    logic [1:0]         grant_idx;
    logic [1:0]         scan_idx;
    logic               done_hit;
    logic               tmo_hit;

    function automatic logic cmd_valid(input logic [CMD_W-1:0] c);
        return (c == CMD_W'(1)) || (c == CMD_W'(2)) || (c == CMD_W'(5)) || (c == CMD_W'(6));
    endfunction

    // State registers for all ports, the shared-unit tracker and the issue hold registers
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= S_IDLE;
                cmd_q[n]   <= '0;
                op1_q[n]   <= '0;
                op2_q[n]   <= '0;
                rdata_q[n] <= '0;
                rcode_q[n] <= '0;
            end
            unit_busy_q <= 1'b0;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd3;
            tmo_cnt_q   <= '0;
            alu_cmd_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                cmd_q[n]   <= cmd_d[n];
                op1_q[n]   <= op1_d[n];
                op2_q[n]   <= op2_d[n];
                rdata_q[n] <= rdata_d[n];
                rcode_q[n] <= rcode_d[n];
            end
            unit_busy_q <= unit_busy_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
        end
    end

    // Round-robin search for the first pending port after the pointer, only when the unit is free
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        if (!unit_busy_q && bus.alu_ready) begin
            for (int i = 1; i <= 4; i++) begin
                scan_idx = rr_ptr_q + 2'(i);
                if (!grant_vld && state_q[scan_idx] == S_PEND) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    // Shared-unit ownership, completion/timeout detection and pointer update
    always_comb begin
        done_hit    = unit_busy_q && bus.alu_done;
        tmo_hit     = unit_busy_q && !bus.alu_done && ((tmo_cnt_q + 11'd2) >= TMO_LIM);
        unit_busy_d = unit_busy_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_cnt_d   = tmo_cnt_q;
        if (done_hit || tmo_hit) begin
            unit_busy_d = 1'b0;
        end else if (grant_vld) begin
            unit_busy_d = 1'b1;
            owner_d     = grant_idx;
            rr_ptr_d    = grant_idx;
            tmo_cnt_d   = '0;
        end else if (unit_busy_q) begin
            tmo_cnt_d   = tmo_cnt_q + 11'd1;
        end
    end

    // Per-port request FSM: capture cmd/op1, capture op2, wait, issue, respond
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            cmd_d[n]   = cmd_q[n];
            op1_d[n]   = op1_q[n];
            op2_d[n]   = op2_q[n];
            rdata_d[n] = rdata_q[n];
            rcode_d[n] = rcode_q[n];
            case (state_q[n])
                S_IDLE: begin
                    if (bus.req_cmd_in[n*CMD_W +: CMD_W] != '0) begin
                        cmd_d[n]   = bus.req_cmd_in[n*CMD_W +: CMD_W];
                        op1_d[n]   = bus.req_data_in[n*DATA_W +: DATA_W];
                        state_d[n] = S_OP2;
                    end
                end
                S_OP2: begin
                    op2_d[n] = bus.req_data_in[n*DATA_W +: DATA_W];
                    if (cmd_valid(cmd_q[n])) begin
                        state_d[n] = S_PEND;
                    end else begin
                        rcode_d[n] = 2'b10;
                        rdata_d[n] = '0;
                        state_d[n] = S_RESP;
                    end
                end
                S_PEND: begin
                    if (grant_vld && grant_idx == 2'(n)) state_d[n] = S_ISSUED;
                end
                S_ISSUED: begin
                    if (owner_q == 2'(n) && done_hit) begin
                        rcode_d[n] = bus.alu_resp;
                        rdata_d[n] = bus.alu_result;
                        state_d[n] = S_RESP;
                    end else if (owner_q == 2'(n) && tmo_hit) begin
                        rcode_d[n] = 2'b11;
                        rdata_d[n] = '0;
                        state_d[n] = S_RESP;
                    end
                end
                S_RESP:  state_d[n] = S_IDLE;
                default: state_d[n] = S_IDLE;
            endcase
        end
    end

    // Issue bus (held between grants) and per-port response/busy outputs
    always_comb begin
        alu_cmd_d = alu_cmd_q;
        alu_op1_d = alu_op1_q;
        alu_op2_d = alu_op2_q;
        if (grant_vld) begin
            alu_cmd_d = cmd_q[grant_idx];
            alu_op1_d = op1_q[grant_idx];
            alu_op2_d = op2_q[grant_idx];
        end
        bus.alu_valid  = grant_vld;
        bus.alu_cmd    = alu_cmd_d;
        bus.alu_op1    = alu_op1_d;
        bus.alu_op2    = alu_op2_d;
        bus.out_data   = '0;
        bus.out_resp   = '0;
        bus.busy_ports = '0;
        for (int n = 0; n < 4; n++) begin
            bus.busy_ports[n] = (state_q[n] != S_IDLE);
            if (state_q[n] == S_RESP) begin
                bus.out_data[n*DATA_W +: DATA_W] = rdata_q[n];
                bus.out_resp[n*2 +: 2]           = rcode_q[n];
            end
        end
    end
endmodule
